// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART receive engine.
// Recovers 5-8 data bits, optional parity and 1-2 stop bits from rx, and
// presents the byte with data-ready, parity, framing and overrun status.
module uart_receiver #(
   parameter int OVS = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       bclk,
   input  logic       rx,
   input  logic [7:0] LCR,
   input  logic       rd,
   output logic [7:0] dout,
   output logic       rx_done,
   output logic       dr,
   output logic       pe,
   output logic       fe,
   output logic       oe
);

   localparam int            CW   = $clog2(OVS);
   localparam logic [CW-1:0] MID  = CW'(OVS / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(OVS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BRK_WAIT
   } state_t;

   // Line-control bits 7:5 carry no receive function.
   logic unused_lcr;
   assign unused_lcr = ^LCR[7:5];

   logic          rx_meta_q, rx_sync_q;
   state_t        state_q, state_d;
   logic [CW-1:0] tick_q, tick_d;
   logic [2:0]    bit_q, bit_d;
   logic [4:0]    lcr_q, lcr_d;
   logic [7:0]    data_q, data_d;
   logic          par_q, par_d;
   logic          fe_acc_q, fe_acc_d;
   logic [7:0]    dout_q, dout_d;
   logic          rx_done_q, rx_done_d;
   logic          dr_q, dr_d;
   logic          pe_q, pe_d;
   logic          fe_q, fe_d;
   logic          oe_q, oe_d;

   logic          frame_done;
   logic          frame_pe;
   logic          frame_fe;
   logic          stop_fe;

   // Two-flop synchronizer for the asynchronous serial line (idles high).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   // Frame FSM next-state logic: tick counting, bit sampling and frame results.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_d    = state_q;
      tick_d     = tick_q;
      bit_d      = bit_q;
      lcr_d      = lcr_q;
      data_d     = data_q;
      par_d      = par_q;
      fe_acc_d   = fe_acc_q;
      frame_done = 1'b0;
      frame_pe   = 1'b0;
      frame_fe   = 1'b0;
      stop_fe    = fe_acc_q | ~rx_sync_q;

      case (state_q)
         S_IDLE: begin
            if (!rx_sync_q) begin
               tick_d   = '0;
               bit_d    = '0;
               lcr_d    = LCR[4:0];
               data_d   = '0;
               par_d    = 1'b0;
               fe_acc_d = 1'b0;
               state_d  = S_START;
            end
         end

         S_START: begin
            if (bclk) begin
               if (tick_q == MID) begin
                  if (rx_sync_q) begin
                     state_d = S_IDLE;
                  end else begin
                     tick_d  = '0;
                     state_d = S_DATA;
                  end
               end else begin
                  tick_d = tick_q + CW'(1);
               end
            end
         end

         S_DATA: begin
            if (bclk) begin
               if (tick_q == LAST) begin
                  tick_d         = '0;
                  data_d[bit_q]  = rx_sync_q;
                  par_d          = par_q ^ rx_sync_q;
                  // Last data bit index is DBIT-1 = 4 + LCR[1:0].
                  if (bit_q == {1'b1, lcr_q[1:0]}) begin
                     bit_d   = '0;
                     state_d = lcr_q[3] ? S_PARITY : S_STOP;
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end else begin
                  tick_d = tick_q + CW'(1);
               end
            end
         end

         S_PARITY: begin
            if (bclk) begin
               if (tick_q == LAST) begin
                  tick_d  = '0;
                  par_d   = par_q ^ rx_sync_q;
                  state_d = S_STOP;
               end else begin
                  tick_d = tick_q + CW'(1);
               end
            end
         end

         S_STOP: begin
            if (bclk) begin
               if (tick_q == LAST) begin
                  tick_d   = '0;
                  fe_acc_d = stop_fe;
                  if (lcr_q[2] && (bit_q == 3'd0)) begin
                     bit_d = 3'd1;
                  end else begin
                     bit_d      = '0;
                     frame_done = 1'b1;
                     frame_fe   = stop_fe;
                     // par_q now holds XOR of data and parity bits.
                     frame_pe   = lcr_q[3] & (lcr_q[4] ? par_q : ~par_q);
                     state_d    = stop_fe ? S_BRK_WAIT : S_IDLE;
                  end
               end else begin
                  tick_d = tick_q + CW'(1);
               end
            end
         end

         S_BRK_WAIT: begin
            if (bclk && rx_sync_q) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Frame FSM state and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         tick_q   <= '0;
         bit_q    <= '0;
         lcr_q    <= '0;
         data_q   <= '0;
         par_q    <= 1'b0;
         fe_acc_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         bit_q    <= bit_d;
         lcr_q    <= lcr_d;
         data_q   <= data_d;
         par_q    <= par_d;
         fe_acc_q <= fe_acc_d;
      end
   end

   // Host-visible status: frame completion has priority over a coincident read.
   always_comb begin
      dout_d    = frame_done ? data_q : dout_q;
      rx_done_d = frame_done;
      dr_d      = frame_done | (dr_q & ~rd);
      pe_d      = frame_done ? frame_pe : (pe_q & ~rd);
      fe_d      = frame_done ? frame_fe : (fe_q & ~rd);
      oe_d      = ~rd & (oe_q | (frame_done & dr_q));
   end

   // Host-visible status registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dout_q    <= '0;
         rx_done_q <= 1'b0;
         dr_q      <= 1'b0;
         pe_q      <= 1'b0;
         fe_q      <= 1'b0;
         oe_q      <= 1'b0;
      end else begin
         dout_q    <= dout_d;
         rx_done_q <= rx_done_d;
         dr_q      <= dr_d;
         pe_q      <= pe_d;
         fe_q      <= fe_d;
         oe_q      <= oe_d;
      end
   end

   assign dout    = dout_q;
   assign rx_done = rx_done_q;
   assign dr      = dr_q;
   assign pe      = pe_q;
   assign fe      = fe_q;
   assign oe      = oe_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver.
// Stimulus serialises frames onto rx and pushes the expected frame result;
// a monitor pops and compares on every rx_done and tracks dr/oe status.
module tb_uart_receiver;

   localparam int OVS  = 16;
   localparam int BDIV = 4;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic       bclk  = 1'b0;
   logic       rx    = 1'b1;
   logic [7:0] LCR   = 8'h03;
   logic       rd    = 1'b0;
   logic [7:0] dout;
   logic       rx_done, dr, pe, fe, oe;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   logic rd_seen  = 1'b0;
   logic m_dr     = 1'b0;
   logic m_oe     = 1'b0;
   int   div      = 0;

   uart_receiver #(.OVS(OVS)) dut (
      .clk     (clk),
      .reset   (reset),
      .bclk    (bclk),
      .rx      (rx),
      .LCR     (LCR),
      .rd      (rd),
      .dout    (dout),
      .rx_done (rx_done),
      .dr      (dr),
      .pe      (pe),
      .fe      (fe),
      .oe      (oe)
   );

   always #5 clk = ~clk;

   // 16x baud tick: one clk-wide pulse every BDIV cycles, changed on negedge.
   always @(negedge clk) begin
      div  = (div + 1) % BDIV;
      bclk = (div == 0);
   end

   // Value of rd seen by the DUT at each active edge.
   always @(posedge clk) rd_seen = rd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares each completed frame and the read-clear behaviour.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         m_dr = 1'b0;
         m_oe = 1'b0;
      end else if (rx_done) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rx_done_unexpected: got frame dout=0x%0h, expected no frame at %0t", dout, $time);
         end else begin
            e = exp_q.pop_front();
            check("dout", dout, e.d);
            check("pe", pe, e.pe);
            check("fe", fe, e.fe);
            m_oe = !rd_seen && (m_oe || m_dr);
            m_dr = 1'b1;
            check("dr_on_frame", dr, m_dr);
            check("oe_on_frame", oe, m_oe);
         end
      end else if (rd_seen) begin
         m_dr = 1'b0;
         m_oe = 1'b0;
         check("dr_after_rd", dr, m_dr);
         check("oe_after_rd", oe, m_oe);
         check("pe_after_rd", pe, 1'b0);
         check("fe_after_rd", fe, 1'b0);
      end
   end

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         do @(posedge clk); while (bclk !== 1'b1);
      end
      #1;
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      wait_ticks(OVS);
   endtask

   task automatic do_rd();
      @(posedge clk);
      #1 rd = 1'b1;
      @(posedge clk);
      #1 rd = 1'b0;
   endtask

   // Serialise one frame; the expected result comes from the frame rules.
   task automatic send_frame(input logic [7:0] lcr_f, input logic [7:0] data, input logic pbit,
                             input logic s0, input logic s1, input logic rd_end,
                             input logic scramble);
      int         nb;
      logic [7:0] d;
      logic       x;
      logic       last;
      exp_t       e;
      nb   = int'(lcr_f[1:0]) + 5;
      d    = data & 8'((1 << nb) - 1);
      x    = (^d) ^ pbit;
      e.d  = d;
      e.pe = lcr_f[3] ? (lcr_f[4] ? x : ~x) : 1'b0;
      e.fe = !s0 || (lcr_f[2] && !s1);
      exp_q.push_back(e);
      LCR = lcr_f;
      send_bit(1'b0);
      if (scramble) LCR = 8'($urandom);
      for (int i = 0; i < nb; i++) send_bit(d[i]);
      if (lcr_f[3]) send_bit(pbit);
      if (lcr_f[2]) begin
         send_bit(s0);
         last = s1;
      end else begin
         last = s0;
      end
      rx = last;
      if (rd_end) begin
         // Land rd on the cycle of the final mid-bit stop sample.
         wait_ticks(OVS / 2 - 1);
         repeat (BDIV - 1) @(posedge clk);
         #1 rd = 1'b1;
         @(posedge clk);
         #1 rd = 1'b0;
         wait_ticks(OVS / 2);
      end else begin
         wait_ticks(OVS);
      end
      rx = 1'b1;
      if (e.fe) wait_ticks(OVS);
   endtask

   initial begin
      #(90000 * 10);
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1);
   end

   initial begin
      exp_t brk;
      logic [7:0] lcr_r, data_r;

      repeat (3) @(posedge clk);
      #1;
      check("reset_dout", dout, 8'h00);
      check("reset_rx_done", rx_done, 1'b0);
      check("reset_dr", dr, 1'b0);
      check("reset_pe", pe, 1'b0);
      check("reset_fe", fe, 1'b0);
      check("reset_oe", oe, 1'b0);
      reset = 1'b1;
      wait_ticks(2 * OVS);

      // 8N1 0xA5, then read clears dr.
      send_frame(8'h03, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      do_rd();

      // 7E2 0x35 with correct then wrong parity bit.
      send_frame(8'h1E, 8'h35, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      send_frame(8'h1E, 8'h35, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      do_rd();

      // False start, then 5N1 0x1F.
      LCR = 8'h00;
      rx  = 1'b0;
      wait_ticks(4);
      rx  = 1'b1;
      wait_ticks(2 * OVS);
      send_frame(8'h00, 8'h1F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      do_rd();

      // Break: line low for 40 bit times yields one frame of zeros with fe.
      LCR    = 8'h03;
      brk.d  = 8'h00;
      brk.pe = 1'b0;
      brk.fe = 1'b1;
      exp_q.push_back(brk);
      rx = 1'b0;
      wait_ticks(40 * OVS);
      rx = 1'b1;
      wait_ticks(2 * OVS);
      send_frame(8'h03, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      do_rd();

      // Overrun, then rd colliding with the third completion.
      send_frame(8'h03, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      send_frame(8'h03, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      send_frame(8'h03, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

      // Reset in the middle of the data bits aborts the frame.
      LCR = 8'h03;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      @(posedge clk);
      #1 reset = 1'b0;
      rx = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("abort_dout", dout, 8'h00);
      check("abort_rx_done", rx_done, 1'b0);
      check("abort_dr", dr, 1'b0);
      check("abort_pe", pe, 1'b0);
      check("abort_fe", fe, 1'b0);
      check("abort_oe", oe, 1'b0);
      reset = 1'b1;
      wait_ticks(2 * OVS);
      send_frame(8'h03, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

      // Randomised frames: formats, parity bits, stop errors, reads, LCR churn.
      for (int i = 0; i < 25; i++) begin
         lcr_r  = 8'($urandom);
         data_r = 8'($urandom);
         send_frame(lcr_r, data_r, 1'($urandom), ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
                    1'($urandom));
         if ($urandom_range(0, 1) == 1) do_rd();
         wait_ticks($urandom_range(0, 20));
      end

      wait_ticks(2 * OVS);
      check("frames_outstanding", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive engine, the receive-side counterpart of the existing transmit path. It runs off the same 16× baud tick `bclk` and the same line-control byte `LCR`. It recovers 5–8 data bits, optional parity and 1–2 stop bits from `rx`, and presents the byte with data-ready, parity, framing and overrun status to the register block.

## Interface
Parameters:
- `OVS`, 16: bclk ticks per bit. The design is verified only at 16.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `bclk`  in  1  one-`clk`-wide enable pulse at 16× baud.
- `rx`  in  1  serial line; idle high; asynchronous to `clk`.
- `LCR`  in  8  line control:
  - [1:0] data bits (00=5, 01=6, 10=7, 11=8).
  - [2] stop bits (0=1, 1=2).
  - [3] parity enable.
  - [4] parity select (0=odd, 1=even).
  - [7:5] ignored.
- `rd`  in  1  one-cycle host read strobe; clears status.
- `dout`  out  8  received byte, right-justified, unused upper bits 0.
- `rx_done`  out  1  one-cycle pulse per completed frame.
- `dr`  out  1  data ready (sticky).
- `pe`  out  1  parity error of the last frame (sticky).
- `fe`  out  1  framing error of the last frame (sticky).
- `oe`  out  1  overrun (sticky).

## Operation
- `rx` passes through a 2-flop synchronizer. All references to `rx` below mean the synchronized value.
- States:
  - IDLE: on `rx`=0, clear the tick counter, latch `LCR[4:0]`, go to START. The latched copy is used for the whole frame; `LCR` changes mid-frame have no effect.
  - START: count `bclk` ticks. On the 8th tick (mid-bit), sample `rx`:
    - `rx`=1: false start; return to IDLE and record nothing.
    - `rx`=0: reset the counter and go to DATA.
  - DATA: sample on every 16th tick. Bits arrive LSB first. After DBIT samples, go to PARITY if parity is enabled, else to STOP.
  - PARITY: sample once after 16 ticks.
    - Odd: error if the XOR of data and parity bits is 0.
    - Even: error if that XOR is 1.
  - STOP: sample after 16 ticks. With 2 stop bits, sample again after another 16 ticks. A frame error is flagged if any sampled stop bit is 0. The frame completes at the last stop sample.
    - All stop bits high: go to IDLE.
    - Otherwise: go to BRK_WAIT.
  - BRK_WAIT: stay until `rx`=1, then go to IDLE. A held-low line therefore produces exactly one frame.
- On frame completion:
  - `dout` is loaded with the data bits, right-justified.
  - `pe` and `fe` are loaded with this frame's results.
  - `oe` is set if `dr` was 1 and `rd` is not asserted in the same cycle.
  - `dr` is set.
  - `rx_done` pulses.
- `rd`=1 clears `dr`, `pe`, `fe` and `oe`. If frame completion and `rd` occur in the same cycle, the completion wins: `dr` becomes 1 and `pe`/`fe` take the new frame's values.
- `dout` holds its value until the next completed frame.

## Timing
- Reset (async assert, sync deassert by the parent): state IDLE, counters 0, `dout`=0, `rx_done`=0, `dr`=`pe`=`fe`=`oe`=0.
- Reset asserted mid-frame aborts the frame. There is no `rx_done` and no status update.
- Tick numbering: T0 is the first `bclk` after IDLE sees `rx`=0.
  - Start sample: T7.
  - Data bit k: T(7+16(k+1)).
  - Parity: T(7+16(DBIT+1)).
  - First stop: 16 ticks after the last data or parity sample.
- `rx_done`, `dout` and the status updates are visible on the `clk` cycle after the final stop-sample tick. `rx_done` is high for exactly one cycle.
- Input-to-detect latency: 2–3 `clk` cycles of synchronizer delay.
- Back-to-back frames: the next start edge is accepted from the first IDLE cycle, i.e. mid-stop-bit. This gives tolerance of about ±4% baud mismatch.
- `bclk` low: all counters hold. `rx` is only sampled on `bclk` cycles, except for start detection in IDLE.

## Test plan
- 8N1, `LCR`=8'h03, frame 0xA5 sent at 16 `bclk`/bit:
  - `rx_done` pulses once; `dout`=8'hA5; `dr`=1; `pe`=`fe`=`oe`=0.
  - `rd` → `dr`=0.
- 7 data bits, even parity, 2 stop (`LCR`=8'h1E), byte 7'h35 with correct parity bit 0:
  - `dout`=8'h35, `pe`=0.
  - Repeat with parity bit 1 → `pe`=1, `dout`=8'h35.
- False start: `rx` low for 4 ticks then high:
  - No `rx_done`; state back to IDLE.
  - A following valid 5N1 frame 5'h1F (`LCR`=8'h00) → `dout`=8'h1F.
- Break: `rx` held low for 40 bit times, 8N1:
  - Exactly one `rx_done`, with `dout`=8'h00 and `fe`=1.
  - No further frames until `rx` returns high, then a valid frame is received normally.
- Overrun and collision:
  - Two frames 0x11 then 0x22 with no `rd` → `dout`=8'h22, `oe`=1, `dr`=1.
  - `rd` coincident with the 3rd frame's completion → `dr`=1, `oe`=0.
- Reset mid-DATA: no `rx_done`; all outputs 0. A subsequent frame 0x3C is received correctly.
